// File: rtl/deserializer.sv
// Serial-to-parallel front end: collects WIDTH qualified bits into one word and
// presents it with a one-cycle valid strobe; flush_i emits a partial word early.
module deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       srst_n_i,
    input  logic                       data_i,
    input  logic                       data_val_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           deser_data_o,
    output logic [$clog2(WIDTH+1)-1:0] deser_len_o,
    output logic                       deser_data_val_o
);

    localparam int LW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("deserializer: WIDTH must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] aligned;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    n;
    logic [LW-1:0]    pad;
    logic             full;
    logic             emit;

    // n includes a bit captured on this same edge, so a flush sees it.
    always_comb begin
        shift_nxt = sreg;
        n         = cnt;
        if (data_val_i) begin
            if (MSB_FIRST) begin
                shift_nxt = {sreg[WIDTH-2:0], data_i};
            end else begin
                shift_nxt = {data_i, sreg[WIDTH-1:1]};
            end
            n = cnt + 1'b1;
        end
        full = data_val_i && (cnt == LW'(WIDTH - 1));
        emit = full || (flush_i && (n != '0));
        pad  = LW'(WIDTH) - n;
        // Shifting by the missing bit count pushes out stale bits and zero-fills the tail.
        if (MSB_FIRST) begin
            aligned = shift_nxt << pad;
        end else begin
            aligned = shift_nxt >> pad;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            sreg             <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_len_o      <= '0;
            deser_data_val_o <= 1'b0;
        end else if (emit) begin
            sreg             <= '0;
            cnt              <= '0;
            deser_data_o     <= aligned;
            deser_len_o      <= n;
            deser_data_val_o <= 1'b1;
        end else begin
            deser_data_val_o <= 1'b0;
            if (data_val_i) begin
                sreg <= shift_nxt;
                cnt  <= n;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed and randomized checks of deserializer for both bit orders (WIDTH=4).
module tb_deserializer;

    localparam int W  = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          srst_n, data, data_val, flush;
    logic [W-1:0]  m_data, l_data;
    logic [LW-1:0] m_len, l_len;
    logic          m_val, l_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(data), .data_val_i(data_val), .flush_i(flush),
        .deser_data_o(m_data), .deser_len_o(m_len), .deser_data_val_o(m_val));

    deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(data), .data_val_i(data_val), .flush_i(flush),
        .deser_data_o(l_data), .deser_len_o(l_len), .deser_data_val_o(l_val));

    typedef struct {
        logic         sr, dv, d, fl;
        logic         ev;
        logic [W-1:0] em, el;
        logic [LW-1:0] len;
    } vec_t;

    vec_t tbl[31];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled at that point.
    task automatic drive(input logic sr, input logic dv, input logic d, input logic fl);
        srst_n = sr; data_val = dv; data = d; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic ev,
                           input logic [W-1:0] em, input logic [W-1:0] el, input logic [LW-1:0] len);
        chk({tag, " msb_val"}, idx, m_val, ev);
        chk({tag, " lsb_val"}, idx, l_val, ev);
        chk({tag, " msb_data"}, idx, m_data, em);
        chk({tag, " lsb_data"}, idx, l_data, el);
        chk({tag, " msb_len"}, idx, m_len, len);
        chk({tag, " lsb_len"}, idx, l_len, len);
    endtask

    bit q[$];
    logic [W-1:0] exp_m, exp_l;
    logic         exp_v;
    logic [LW-1:0] exp_len;

    initial begin
        //           sr  dv  d   fl   ev  msb      lsb      len
        tbl[0]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,4'b1001,4'b1001,3'd4};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,4'b1001,4'b1001,3'd4};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1001,4'b1001,3'd4};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1001,4'b1001,3'd4};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b1001,4'b1001,3'd4};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,4'b1101,4'b1011,3'd4};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1101,4'b1011,3'd4};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1101,4'b1011,3'd4};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,4'b1100,4'b0011,3'd2};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,4'b1100,4'b0011,3'd2};
        tbl[13] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1100,4'b0011,3'd2};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,4'b1000,4'b0001,3'd2};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b1000,4'b0001,3'd2};
        tbl[16] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1000,4'b0001,3'd2};
        tbl[17] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1000,4'b0001,3'd2};
        tbl[18] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,4'b0110,4'b0110,3'd4};
        tbl[19] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,4'b0110,4'b0110,3'd4};
        tbl[20] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,4'b1000,4'b0001,3'd1};
        tbl[21] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1000,4'b0001,3'd1};
        tbl[22] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b1000,4'b0001,3'd1};
        tbl[23] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,4'b1000,4'b0001,3'd1};
        tbl[24] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[25] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[26] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[27] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,4'b0000,4'b0000,3'd0};
        tbl[28] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,4'b0001,4'b1000,3'd4};
        tbl[29] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,4'b0001,4'b1000,3'd4};
        tbl[30] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,4'b0001,4'b1000,3'd4};

        srst_n = 1'b0; data_val = 1'b0; data = 1'b0; flush = 1'b0;

        // Reset held three cycles, then ten idle cycles with no strobe.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("reset", 0, 1'b0, 4'b0000, 4'b0000, 3'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            chk_all("idle", i, 1'b0, 4'b0000, 4'b0000, 3'd0);
        end

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].sr, tbl[i].dv, tbl[i].d, tbl[i].fl);
            chk_all("vec", i, tbl[i].ev, tbl[i].em, tbl[i].el, tbl[i].len);
        end

        // Bits 1,1,0,0 with two idle cycles between each; one strobe at the last bit.
        begin
            logic [3:0] bits;
            bits = 4'b0011;
            for (int b = 0; b < 4; b++) begin
                drive(1'b1, 1'b1, bits[b], 1'b0);
                if (b == 3) chk_all("gaps", b, 1'b1, 4'b1100, 4'b0011, 3'd4);
                else        chk_all("gaps", b, 1'b0, 4'b0001, 4'b1000, 3'd4);
                if (b < 3) begin
                    for (int g = 0; g < 2; g++) begin
                        drive(1'b1, 1'b0, ~bits[b], 1'b0);
                        chk_all("gap_idle", b * 2 + g, 1'b0, 4'b0001, 4'b1000, 3'd4);
                    end
                end
            end
        end

        // Continuous stream with random flushes against a bit-list reference model.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic d, fl;
            d  = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 6) == 0);
            drive(1'b1, 1'b1, d, fl);
            q.push_back(d);
            exp_v = (q.size() == W) || (fl && q.size() > 0);
            chk("rnd msb_val", i, m_val, exp_v);
            chk("rnd lsb_val", i, l_val, exp_v);
            if (exp_v) begin
                exp_m = '0;
                exp_l = '0;
                for (int k = 0; k < q.size(); k++) begin
                    exp_m[W-1-k] = q[k];
                    exp_l[k]     = q[k];
                end
                exp_len = LW'(q.size());
                chk("rnd msb_data", i, m_data, exp_m);
                chk("rnd lsb_data", i, l_data, exp_l);
                chk("rnd msb_len", i, m_len, exp_len);
                chk("rnd lsb_len", i, l_len, exp_len);
                q.delete();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
